// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the pixel fetch sequencer.
//   fetch_state_e : sequencer state encoding
//   pix_tag_t     : address tag travelling with each read beat (row, col,
//                   template flag, window index); fields are sized for the
//                   largest supported frame and truncated by the user.
//   clog2_min1    : $clog2 clamped to a minimum of 1 bit
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TEMPLATE = 3'd1,
    ST_WINDOW   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } fetch_state_e;

  localparam int TAG_FIELD_W = 16;

  typedef struct packed {
    logic [TAG_FIELD_W-1:0] row;
    logic [TAG_FIELD_W-1:0] col;
    logic                   tem;
    logic [TAG_FIELD_W-1:0] win;
  } pix_tag_t;

  localparam int TAG_W = $bits(pix_tag_t);

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// fetch_tag_fifo: DEPTH-entry first-word-fall-through buffer for read data
// plus its tag. A push into a full buffer is accepted when a pop happens in
// the same cycle.
//   push/push_data : write one entry
//   pop            : consume head entry (ignored when empty)
//   head           : current head entry, stable until popped
//   full/empty/count : occupancy status
module fetch_tag_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pixel_fetch_seq.sv
// pixel_fetch_seq: reads one template frame and NUM_WIN window frames from
// a fixed-latency memory in row-major order and streams the returned pixels,
// each tagged with its address, over a valid/ready interface.
//   ready_2_start        : start request, sampled in IDLE; also releases DONE
//   req/rd_wr/row/col/tem_win/win_idx : read strobe and address
//   read_data            : valid RD_LAT cycles after each req
//   pix_valid/pix_ready, pix_data/row/col/tem/win : tagged pixel stream
//   set_done             : high while in DONE
//   stall_cycles         : only with FETCH_STALL_CNT_EN, counts credit stalls
//
// state    | meaning
// IDLE     | waiting for ready_2_start
// TEMPLATE | issuing template frame reads
// WINDOW   | issuing window frame reads
// DRAIN    | all reads issued, waiting for in-flight and buffered beats
// DONE     | run complete, waiting for ready_2_start to drop
module pixel_fetch_seq
  import fetch_pkg::*;
#(
  parameter int ROWS    = 64,
  parameter int COLS    = 64,
  parameter int NUM_WIN = 4,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  localparam int ROW_W  = clog2_min1(ROWS),
  localparam int COL_W  = clog2_min1(COLS),
  localparam int WIN_W  = clog2_min1(NUM_WIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready_2_start,
  output logic              req,
  output logic              rd_wr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              tem_win,
  output logic [WIN_W-1:0]  win_idx,
  input  logic [DATA_W-1:0] read_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [ROW_W-1:0]  pix_row,
  output logic [COL_W-1:0]  pix_col,
  output logic              pix_tem,
  output logic [WIN_W-1:0]  pix_win,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              set_done
);

  localparam int DEPTH  = RD_LAT + 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FIFO_W = TAG_W + DATA_W;

  fetch_state_e     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             tem_q, tem_d;
  logic [WIN_W-1:0] win_q, win_d;

  // Tag pipeline mirroring the memory latency; stage RD_LAT-1 lines up with
  // the cycle its read_data is on the bus.
  logic [RD_LAT-1:0] vld_q, vld_d;
  pix_tag_t          tag_q [RD_LAT];
  pix_tag_t          tag_d [RD_LAT];
  pix_tag_t          cur_tag, head_tag;

  logic [CNT_W-1:0]  infl_cnt, fifo_cnt;
  logic [CNT_W:0]    occ;
  logic              run, fifo_full, fifo_empty, pop;
  logic [FIFO_W-1:0] fifo_head;
  logic              unused_bits;

  assign run = (state_q == ST_TEMPLATE) || (state_q == ST_WINDOW);

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + CNT_W'(vld_q[i]);
  end

  // Credit: a req is only issued if its beat is guaranteed a buffer slot.
  assign occ = {1'b0, infl_cnt} + {1'b0, fifo_cnt};
  assign req = run && (occ < (CNT_W + 1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tem_d   = tem_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (ready_2_start) begin
          state_d = ST_TEMPLATE;
          tem_d   = 1'b1;
          row_d   = '0;
          col_d   = '0;
          win_d   = '0;
        end
      end
      ST_TEMPLATE, ST_WINDOW: begin
        if (req) begin
          if (col_q != COL_W'(COLS - 1)) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            if (row_q != ROW_W'(ROWS - 1)) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              row_d = '0;
              if (tem_q) begin
                tem_d   = 1'b0;
                win_d   = '0;
                state_d = ST_WINDOW;
              end else if (win_q != WIN_W'(NUM_WIN - 1)) begin
                win_d = win_q + WIN_W'(1);
              end else begin
                win_d   = '0;
                state_d = ST_DRAIN;
              end
            end
          end
        end
      end
      ST_DRAIN: if (infl_cnt == '0 && fifo_empty) state_d = ST_DONE;
      ST_DONE:  if (!ready_2_start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_tag.row = TAG_FIELD_W'(row_q);
    cur_tag.col = TAG_FIELD_W'(col_q);
    cur_tag.tem = tem_q;
    cur_tag.win = TAG_FIELD_W'(win_q);
    vld_d[0] = req;
    tag_d[0] = cur_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tem_q   <= 1'b0;
      win_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tem_q   <= tem_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
    end
  end

  fetch_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_q[RD_LAT-1]),
    .push_data ({tag_q[RD_LAT-1], read_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign pop       = pix_valid && pix_ready;
  assign head_tag  = fifo_head[FIFO_W-1 -: TAG_W];
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_head[DATA_W-1:0];
  assign pix_row   = head_tag.row[ROW_W-1:0];
  assign pix_col   = head_tag.col[COL_W-1:0];
  assign pix_tem   = head_tag.tem;
  assign pix_win   = head_tag.win[WIN_W-1:0];

  // Upper tag bits beyond the frame size and the full flag are not needed.
  assign unused_bits = ^{head_tag, fifo_full};

  assign rd_wr    = 1'b0;
  assign row      = row_q;
  assign col      = col_q;
  assign tem_win  = tem_q;
  assign win_idx  = win_q;
  assign set_done = (state_q == ST_DONE);

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && ready_2_start) stall_d = '0;
    else if (run && !req && stall_q != '1)   stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_fetch_seq.sv
// Scoreboard bench for pixel_fetch_seq (ROWS=COLS=4, NUM_WIN=3, RD_LAT=3).
module tb_pixel_fetch_seq;

  localparam int ROWS = 4, COLS = 4, NUM_WIN = 3, RD_LAT = 3, DATA_W = 32;
  localparam int BEATS = (NUM_WIN + 1) * ROWS * COLS;
  localparam int DEPTH = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ready_2_start;
  logic              req, rd_wr, tem_win, pix_valid, pix_ready, pix_tem, set_done;
  logic [1:0]        row, col, win_idx, pix_row, pix_col, pix_win;
  logic [DATA_W-1:0] read_data, pix_data;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  pixel_fetch_seq #(
    .ROWS(ROWS), .COLS(COLS), .NUM_WIN(NUM_WIN), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready_2_start(ready_2_start),
    .req(req), .rd_wr(rd_wr), .row(row), .col(col), .tem_win(tem_win),
    .win_idx(win_idx), .read_data(read_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_row(pix_row), .pix_col(pix_col), .pix_tem(pix_tem), .pix_win(pix_win),
`ifdef FETCH_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .set_done(set_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  int          ready_mode = 1;  // 0: hold low, 1: hold high, 2: random 50%
  logic [38:0] exp_q[$];

  function automatic logic [31:0] mem_val(int t, int w, int r, int c);
    return {(t != 0) ? 8'hC0 : 8'h3A, 8'(w), 8'(r), 8'(c)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference order: whole template frame, then each window, row-major.
  task automatic push_expected();
    for (int t = 0; t <= NUM_WIN; t++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          int tem = (t == 0) ? 1 : 0;
          int w   = (t == 0) ? 0 : t - 1;
          exp_q.push_back({mem_val(tem, w, r, c), 2'(r), 2'(c), 1'(tem), 2'(w)});
        end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input bit hold);
    push_expected();
    @(posedge clk);
    #1 ready_2_start = 1'b1;
    nstep();
    chk("idle_before_start", req, 0);
    nstep();
    chk("first_req", {req, row, col, tem_win, win_idx}, 8'b1_00_00_1_00);
    if (!hold) ready_2_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!set_done && n < budget) begin
      nstep();
      n++;
    end
    chk("done_reached", set_done, 1);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    ready_2_start = 1'b0;
    read_data = '0;
    pix_ready = 1'b1;

    fork
      // memory: answers each req RD_LAT cycles later with data keyed on address
      begin
        logic [31:0] pipe [RD_LAT];
        for (int i = 0; i < RD_LAT; i++) pipe[i] = $urandom;
        forever begin
          @(negedge clk);
          read_data = pipe[RD_LAT-1];
          for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
          pipe[0] = req ? mem_val(int'(tem_win), int'(win_idx), int'(row), int'(col)) : $urandom;
        end
      end
      begin
        forever begin
          @(posedge clk);
          #1;
          pix_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
        end
      end
      begin
        forever begin
          @(negedge clk);
          if (rst_n && req) req_cnt++;
        end
      end
      // monitor: scoreboard pop on handshake plus hold-stability check
      begin
        logic        hold = 1'b0;
        logic [39:0] held = '0;
        logic [38:0] e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            hold = 1'b0;
          end else begin
            if (hold)
              chk("pix_stable", {pix_valid, pix_data, pix_row, pix_col, pix_tem, pix_win}, held);
            if (pix_valid && pix_ready) begin
              if (exp_q.size() == 0) begin
                chk("no_extra_pixel", 1, 0);
              end else begin
                e = exp_q.pop_front();
                chk("pixel", {pix_data, pix_row, pix_col, pix_tem, pix_win}, e);
              end
            end
            hold = pix_valid && !pix_ready;
            held = {pix_valid, pix_data, pix_row, pix_col, pix_tem, pix_win};
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) nstep();
    chk("reset_outputs", {req, pix_valid, set_done, row, col, tem_win, win_idx}, 0);
    chk("rd_wr_zero", rd_wr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // run 1: free-flowing sink, start held through DONE
    ready_mode = 1;
    base = req_cnt;
    start_run(1'b1);
    wait_done(1000);
    chk("run1_all_delivered", exp_q.size(), 0);
    chk("run1_req_count", req_cnt - base, BEATS);
    for (int i = 0; i < 5; i++) begin
      nstep();
      chk("done_hold", {set_done, req}, 2'b10);
    end
    @(posedge clk);
    #1 ready_2_start = 1'b0;
    nstep();
    nstep();
    chk("done_to_idle", set_done, 0);

    // run 2: sink blocked, credit limit, then random sink; start dropped early
    ready_mode = 0;
    base = req_cnt;
    start_run(1'b0);
    repeat (20) nstep();
    chk("credit_reqs", req_cnt - base, DEPTH);
    chk("credit_req_low", {req, pix_valid}, 2'b01);
    chk("next_addr_held", {row, col, tem_win}, 5'b01_01_1);
`ifdef FETCH_STALL_CNT_EN
    begin
      logic [31:0] s0;
      s0 = stall_cycles;
      repeat (10) nstep();
      chk("stall_cycles", stall_cycles - s0, 10);
    end
`endif
    ready_mode = 2;
    wait_done(3000);
    chk("run2_all_delivered", exp_q.size(), 0);
    chk("run2_req_count", req_cnt - base, BEATS);
    nstep();
    chk("run2_idle", set_done, 0);

    // run 3: reset after 5 beats, stale read data must be dropped
    base = req_cnt;
    start_run(1'b1);
    n = 0;
    while ((req_cnt - base) < 5 && n < 500) begin
      nstep();
      n++;
    end
    chk("reached_beat5", (req_cnt - base) >= 5, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    ready_2_start = 1'b0;
    #1;
    chk("midrun_reset_outputs", {req, pix_valid, set_done, row, col, tem_win, win_idx}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = req_cnt;
    start_run(1'b1);
    wait_done(3000);
    chk("run3_all_delivered", exp_q.size(), 0);
    chk("run3_req_count", req_cnt - base, BEATS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
